// File: rtl/serial_cla_sequencer.sv
// Time-multiplexed WORDS x 4-bit add/subtract controller.
// Feeds one nibble per cycle to an external 4-bit lookahead slice and chains its carry through a register.
module serial_cla_sequencer #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sub,
  input  logic [4*WORDS-1:0] a,
  input  logic [4*WORDS-1:0] b,
  output logic               busy,
  output logic               done,
  output logic [4*WORDS-1:0] sum,
  output logic               cout,
  output logic               ovf,
  output logic [3:0]         slice_a,
  output logic [3:0]         slice_b,
  output logic               slice_cin,
  input  logic [3:0]         slice_f,
  input  logic               slice_cout
);

  localparam int N    = 4 * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [N-1:0]    opa_r;
  logic [N-1:0]    opb_r;
  logic            carry_r;
  logic [IDXW-1:0] idx_r;
  logic [N-1:0]    sum_r;
  logic            cout_r;
  logic            ovf_r;
  logic [IDXW+1:0] bit_pos_s;

  assign bit_pos_s = {idx_r, 2'b00};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (idx_r == LAST_IDX) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Operand latch, carry chain and nibble-wise result collection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_r   <= {N{1'b0}};
      opb_r   <= {N{1'b0}};
      carry_r <= 1'b0;
      idx_r   <= {IDXW{1'b0}};
      sum_r   <= {N{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            opa_r   <= a;
            opb_r   <= sub ? ~b : b;
            carry_r <= sub;
            idx_r   <= {IDXW{1'b0}};
          end
        end
        RUN: begin
          sum_r[bit_pos_s +: 4] <= slice_f;
          carry_r               <= slice_cout;
          idx_r                 <= idx_r + IDXW'(1);
          // Overflow judged on the effective (possibly inverted) operands
          if (idx_r == LAST_IDX) begin
            cout_r <= slice_cout;
            ovf_r  <= (opa_r[N-1] == opb_r[N-1]) && (slice_f[3] != opa_r[N-1]);
          end
        end
        default: begin
          carry_r <= carry_r;
        end
      endcase
    end
  end

  // Output decode and slice drive
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    slice_a   = 4'h0;
    slice_b   = 4'h0;
    slice_cin = 1'b0;
    case (state_r)
      RUN: begin
        busy      = 1'b1;
        slice_a   = opa_r[bit_pos_s +: 4];
        slice_b   = opb_r[bit_pos_s +: 4];
        slice_cin = carry_r;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_cla_sequencer.sv
// Scoreboard bench for serial_cla_sequencer with a behavioural 4-bit slice and an arithmetic reference model.
module tb_serial_cla_sequencer;

  localparam int  WORDS = 4;
  localparam int  N     = 4 * WORDS;
  localparam time T     = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy, done, cout, ovf, slice_cin, slice_cout;
  logic [N-1:0] sum;
  logic [3:0]   slice_a, slice_b, slice_f;

  serial_cla_sequencer #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_f(slice_f), .slice_cout(slice_cout)
  );

  always #(T/2) clk = ~clk;

  // External 4-bit adder slice
  assign {slice_cout, slice_f} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_cin};

  typedef struct {
    logic [N-1:0] s;
    logic         c;
    logic         o;
    time          t0;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv, input logic sv);
    exp_t         e;
    logic [N-1:0] eb;
    logic [N:0]   full;
    longint       r;
    eb   = sv ? ~bv : bv;
    full = {1'b0, av} + {1'b0, eb} + (N+1)'(sv);
    r    = longint'($signed(av)) + longint'($signed(eb)) + longint'(sv);
    e.s  = full[N-1:0];
    e.c  = full[N];
    e.o  = (r > (longint'(1) <<< (N-1)) - 1) || (r < -(longint'(1) <<< (N-1)));
    e.t0 = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.c));
        chk("ovf", 32'(ovf), 32'(e.o));
        chk("done_latency", 32'($time - e.t0), 32'(WORDS * T + T / 2));
      end
    end
  end

  // Issue one operation from an idle negedge; optionally pulse start during RUN and DONE
  task automatic do_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic sv, input bit inject);
    exp_t         e;
    logic [N-1:0] eb;
    time          t0;
    int           n;
    eb    = sv ? ~bv : bv;
    a     = av;
    b     = bv;
    sub   = sv;
    start = 1'b1;
    @(posedge clk);
    t0   = $time;
    e    = model(av, bv, sv);
    e.t0 = t0;
    sb_q.push_back(e);
    #1;
    start = 1'b0;
    a     = N'($urandom);
    b     = N'($urandom);
    sub   = 1'($urandom);
    @(negedge clk);
    chk("busy_run", 32'(busy), 32'd1);
    chk("slice_a0", 32'(slice_a), 32'(av[3:0]));
    chk("slice_b0", 32'(slice_b), 32'(eb[3:0]));
    chk("slice_cin0", 32'(slice_cin), 32'(sv));
    if (inject) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
    end
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("busy_fall_time", 32'($time - t0), 32'((WORDS + 1) * T + T / 2));
    chk("sum_held", 32'(sum), 32'(e.s));
    chk("cout_held", 32'(cout), 32'(e.c));
    chk("ovf_held", 32'(ovf), 32'(e.o));
    chk("slice_idle", {27'd0, slice_a, slice_cin}, 32'd0);
    chk("pending_done", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'd0);
    chk({tag, "_cout_ovf"}, {30'd0, cout, ovf}, 32'd0);
    chk({tag, "_slice"}, {23'd0, slice_a, slice_b, slice_cin}, 32'd0);
  endtask

  initial begin
    #(20 * 1000 * T);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    do_op(16'h1234, 16'h1111, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b0);
    do_op(16'h4321, 16'h0F0F, 1'b0, 1'b1);

    // Reset in the middle of RUN (idx == 2)
    a     = 16'hABCD;
    b     = 16'h1111;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    e    = model(16'hABCD, 16'h1111, 1'b0);
    e.t0 = $time;
    sb_q.push_back(e);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_state("midrun_rst");
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_sum", 32'(sum), 32'd0);
    do_op(16'h0001, 16'h0002, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      do_op(N'($urandom), N'($urandom), 1'($urandom), ($urandom_range(3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
